// File: rtl/boss_phase_sequencer.sv
// Boss behaviour controller: phase FSM with difficulty/enrage-scaled timing
// and a volley or round-robin firing pattern across NUM_GUNS channels.
module boss_phase_sequencer #(
   parameter int unsigned NUM_GUNS     = 4,
   parameter int unsigned TW           = 11,
   parameter int unsigned SPAWN_WAIT   = 255,
   parameter int unsigned CRUISE_TIME  = 2047,
   parameter int unsigned DROP_WAIT    = 255,
   parameter int unsigned SHOT_PERIOD  = 31,
   parameter int unsigned ENRAGE_DIVES = 3
) (
   input  logic                frame_clk,
   input  logic                Reset_n,
   input  logic                start_boss,
   input  logic [2:0]          difficulty,
   input  logic                beat_boss,
   input  logic                hit_bottom,
   input  logic                hit_top,
   output logic                boss_hold,
   output logic                boss_back_and_forth,
   output logic                boss_flydown,
   output logic                boss_rise,
   output logic                boss_exists,
   output logic [NUM_GUNS-1:0] boss_shoot,
   output logic [3:0]          dive_count
);

   localparam int unsigned GW = (NUM_GUNS > 1) ? $clog2(NUM_GUNS) : 1;

   localparam logic [TW-1:0] SPAWN_LD  = TW'(SPAWN_WAIT);
   localparam logic [TW-1:0] CRUISE_LD = TW'(CRUISE_TIME);
   localparam logic [TW-1:0] DROP_LD   = TW'(DROP_WAIT);
   localparam logic [TW-1:0] SHOT_LD   = TW'(SHOT_PERIOD);

   typedef enum logic [2:0] {
      S_HIDE,
      S_SPAWN_HOLD,
      S_CRUISE,
      S_WAIT_DROP,
      S_DIVE,
      S_RISE,
      S_DEFEATED
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [TW-1:0]   shot_q, shot_d;
   logic [GW-1:0]   gun_q, gun_d;
   logic [3:0]      dive_q, dive_d;
   logic [2:0]      lvl_sum;
   logic [1:0]      lvl;
   logic            enraged;
   logic            fire;
   logic            tmr_zero;
   logic            spawning;

   assign dive_count = dive_q;
   assign tmr_zero   = (tmr_q == '0);
   assign spawning   = (state_q == S_HIDE) && (state_d == S_SPAWN_HOLD);

   always_comb begin
      enraged = (32'(dive_q) >= ENRAGE_DIVES);
      lvl_sum = {1'b0, difficulty[1:0]} + {2'b00, enraged};
      lvl     = (lvl_sum > 3'd3) ? 2'd3 : lvl_sum[1:0];
   end

   // State register
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_HIDE;
      else          state_q <= state_d;
   end

   // Next-state logic; beat_boss wins over everything in the active states
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HIDE:       if (start_boss && !beat_boss) state_d = S_SPAWN_HOLD;
         S_SPAWN_HOLD: if (beat_boss) state_d = S_DEFEATED;
                       else if (tmr_zero) state_d = S_CRUISE;
         S_CRUISE:     if (beat_boss) state_d = S_DEFEATED;
                       else if (tmr_zero) state_d = S_WAIT_DROP;
         S_WAIT_DROP:  if (beat_boss) state_d = S_DEFEATED;
                       else if (tmr_zero) state_d = S_DIVE;
         S_DIVE:       if (beat_boss) state_d = S_DEFEATED;
                       else if (hit_bottom) state_d = S_RISE;
         S_RISE:       if (beat_boss) state_d = S_DEFEATED;
                       else if (hit_top) state_d = S_SPAWN_HOLD;
         S_DEFEATED:   if (!start_boss) state_d = S_HIDE;
         default:      state_d = S_HIDE;
      endcase
   end

   // Motion command decode
   always_comb begin
      boss_hold           = (state_q == S_SPAWN_HOLD) || (state_q == S_WAIT_DROP);
      boss_back_and_forth = (state_q == S_CRUISE);
      boss_flydown        = (state_q == S_DIVE);
      boss_rise           = (state_q == S_RISE);
      boss_exists         = (state_q != S_HIDE) && (state_q != S_DEFEATED);
   end

   always_comb begin
      tmr_d  = tmr_q;
      shot_d = shot_q;
      gun_d  = gun_q;
      dive_d = dive_q;
      fire   = 1'b0;

      if (state_d != state_q) begin
         case (state_d)
            S_SPAWN_HOLD: tmr_d = SPAWN_LD;
            S_CRUISE:     tmr_d = CRUISE_LD >> lvl;
            S_WAIT_DROP:  tmr_d = DROP_LD >> lvl;
            default:      tmr_d = tmr_q;
         endcase
      end else if ((state_q == S_SPAWN_HOLD) || (state_q == S_CRUISE) ||
                   (state_q == S_WAIT_DROP)) begin
         tmr_d = tmr_q - TW'(1);
      end

      if (spawning)
         dive_d = '0;
      else if ((state_q == S_RISE) && (state_d == S_SPAWN_HOLD) && (dive_q != 4'hF))
         dive_d = dive_q + 4'd1;

      if (boss_exists) begin
         if (shot_q == '0) begin
            fire   = 1'b1;
            shot_d = SHOT_LD >> lvl;
            if (difficulty[2])
               gun_d = (gun_q == GW'(NUM_GUNS - 1)) ? '0 : gun_q + GW'(1);
         end else begin
            shot_d = shot_q - TW'(1);
         end
      end else begin
         gun_d = '0;
         if (spawning) shot_d = SHOT_LD >> lvl;
      end
   end

   always_comb begin
      boss_shoot = '0;
      if (fire) begin
         if (difficulty[2]) begin
            for (int unsigned g = 0; g < NUM_GUNS; g++)
               boss_shoot[g] = (GW'(g) == gun_q);
         end else begin
            boss_shoot = '1;
         end
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tmr_q  <= '0;
         shot_q <= '0;
         gun_q  <= '0;
         dive_q <= '0;
      end else begin
         tmr_q  <= tmr_d;
         shot_q <= shot_d;
         gun_q  <= gun_d;
         dive_q <= dive_d;
      end
   end

endmodule

// File: tb/tb_boss_phase_sequencer.sv
// Directed and randomized bench for boss_phase_sequencer against a
// cycle-counting reference model of the phase and firing rules.
module tb_boss_phase_sequencer;

   localparam int SPW = 3, CRT = 15, DRW = 3, SHP = 7, NG = 4, ENR = 2;
   localparam int M_HIDE = 0, M_SPAWN = 1, M_CRUISE = 2, M_WAIT = 3,
                  M_DIVE = 4, M_RISE = 5, M_DEF = 6;

   logic          frame_clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          start_boss = 1'b0;
   logic [2:0]    difficulty = 3'd0;
   logic          beat_boss = 1'b0;
   logic          hit_bottom = 1'b0;
   logic          hit_top = 1'b0;
   logic          boss_hold, boss_back_and_forth, boss_flydown, boss_rise, boss_exists;
   logic [NG-1:0] boss_shoot;
   logic [3:0]    dive_count;

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase, cycles spent in it, its total length,
   // cycles since last shot-timer load and the interval that load set
   int m_phase, m_elapsed, m_len, m_since, m_interval, m_gun, m_dives;

   boss_phase_sequencer #(
      .NUM_GUNS(NG), .TW(11), .SPAWN_WAIT(SPW), .CRUISE_TIME(CRT),
      .DROP_WAIT(DRW), .SHOT_PERIOD(SHP), .ENRAGE_DIVES(ENR)
   ) dut (
      .frame_clk(frame_clk), .Reset_n(Reset_n), .start_boss(start_boss),
      .difficulty(difficulty), .beat_boss(beat_boss), .hit_bottom(hit_bottom),
      .hit_top(hit_top), .boss_hold(boss_hold),
      .boss_back_and_forth(boss_back_and_forth), .boss_flydown(boss_flydown),
      .boss_rise(boss_rise), .boss_exists(boss_exists), .boss_shoot(boss_shoot),
      .dive_count(dive_count)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_lvl();
      int l;
      l = int'(difficulty[1:0]) + ((m_dives >= ENR) ? 1 : 0);
      return (l > 3) ? 3 : l;
   endfunction

   function automatic bit m_active();
      return (m_phase != M_HIDE) && (m_phase != M_DEF);
   endfunction

   function automatic bit m_fire();
      return m_active() && (m_since == m_interval - 1);
   endfunction

   function automatic logic [31:0] m_vec();
      logic [3:0] sh;
      sh = 4'h0;
      if (m_fire()) sh = difficulty[2] ? (4'h1 << m_gun) : 4'hF;
      return {19'd0, m_phase == M_SPAWN || m_phase == M_WAIT, m_phase == M_CRUISE,
              m_phase == M_DIVE, m_phase == M_RISE, m_active(), sh, 4'(m_dives)};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {19'd0, boss_hold, boss_back_and_forth, boss_flydown, boss_rise,
              boss_exists, boss_shoot, dive_count};
   endfunction

   task automatic m_reset();
      m_phase = M_HIDE; m_elapsed = 0; m_len = 1; m_since = 0;
      m_interval = 1; m_gun = 0; m_dives = 0;
   endtask

   task automatic m_enter(input int ph, input int len);
      m_phase = ph; m_elapsed = 0; m_len = len;
   endtask

   task automatic m_step();
      int l;
      bit last;
      l = m_lvl();
      last = (m_elapsed == m_len - 1);
      if (m_active()) begin
         if (m_fire()) begin
            m_since = 0;
            m_interval = (SHP >> l) + 1;
            if (difficulty[2]) m_gun = (m_gun + 1) % NG;
         end else begin
            m_since++;
         end
      end else begin
         m_gun = 0;
      end
      if (m_phase == M_HIDE) begin
         if (start_boss && !beat_boss) begin
            m_enter(M_SPAWN, SPW + 1);
            m_since = 0; m_interval = (SHP >> l) + 1; m_dives = 0;
         end
      end else if (m_phase == M_DEF) begin
         if (!start_boss) m_phase = M_HIDE;
      end else if (beat_boss) begin
         m_phase = M_DEF;
      end else begin
         case (m_phase)
            M_SPAWN:  if (last) m_enter(M_CRUISE, (CRT >> l) + 1); else m_elapsed++;
            M_CRUISE: if (last) m_enter(M_WAIT, (DRW >> l) + 1); else m_elapsed++;
            M_WAIT:   if (last) m_enter(M_DIVE, 1); else m_elapsed++;
            M_DIVE:   if (hit_bottom) m_enter(M_RISE, 1);
            M_RISE:   if (hit_top) begin
                         m_enter(M_SPAWN, SPW + 1);
                         if (m_dives < 15) m_dives++;
                      end
            default:  m_phase = M_HIDE;
         endcase
      end
   endtask

   task automatic tick();
      @(negedge frame_clk);
      if (!Reset_n) m_reset();
      chk("cycle", dut_vec(), m_vec());
      if (!Reset_n) m_reset(); else m_step();
      @(posedge frame_clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return boss_hold;
         1: return boss_back_and_forth;
         2: return boss_flydown;
         default: return boss_rise;
      endcase
   endfunction

   task automatic run_while(input int sel, output int n);
      n = 0;
      while (sig(sel) && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_shot(output int n, output logic [3:0] v);
      n = 0;
      while (boss_shoot == '0 && n < 50) begin
         tick();
         n++;
      end
      v = boss_shoot;
   endtask

   initial begin
      int n;
      logic [3:0] v;
      m_reset();
      tick();
      tick();
      chk("reset_outputs", dut_vec(), 32'd0);
      Reset_n = 1'b1;
      tick();

      // volley at level 1, then defeat on the cycle CRUISE expires
      difficulty = 3'b001;
      start_boss = 1'b1;
      tick();
      start_boss = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k == 11) beat_boss = 1'b1;
         chk("volley_shot", 32'(boss_shoot), ((k % 4) == 3) ? 32'hF : 32'h0);
         chk("cruise_l1", 32'(boss_back_and_forth), (k >= 4) ? 32'd1 : 32'd0);
         tick();
      end
      beat_boss = 1'b0;
      chk("defeated_outputs", dut_vec(), 32'd0);
      start_boss = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("defeat_sticky", dut_vec(), 32'd0);
      start_boss = 1'b0;
      tick();

      // a start after release proves HIDE was reached
      difficulty = 3'b000;
      start_boss = 1'b1;
      tick();
      start_boss = 1'b0;
      chk("hide_after_defeat", 32'(boss_hold), 32'd1);
      run_while(0, n); chk("spawn_len", 32'(n), 32'd4);
      run_while(1, n); chk("cruise_len_l0", 32'(n), 32'd16);
      run_while(0, n); chk("wait_len_l0", 32'(n), 32'd4);
      chk("dive_entered", 32'(boss_flydown), 32'd1);
      for (int k = 0; k < 5; k++) tick();
      chk("dive_held", 32'(boss_flydown), 32'd1);
      hit_bottom = 1'b1; hit_top = 1'b1;
      tick();
      hit_top = 1'b0; hit_bottom = 1'b0;
      chk("both_hits_in_dive", 32'(boss_rise), 32'd1);
      tick(); tick();
      hit_top = 1'b1; hit_bottom = 1'b1;
      tick();
      hit_top = 1'b0; hit_bottom = 1'b0;
      chk("dive_count_1", 32'(dive_count), 32'd1);
      chk("respawn_hold", 32'(boss_hold), 32'd1);

      run_while(0, n); chk("spawn_len_2", 32'(n), 32'd4);
      run_while(1, n); chk("cruise_len_2", 32'(n), 32'd16);
      run_while(0, n); chk("wait_len_2", 32'(n), 32'd4);
      tick();
      hit_bottom = 1'b1; tick(); hit_bottom = 1'b0;
      tick();
      hit_top = 1'b1; tick(); hit_top = 1'b0;
      chk("dive_count_2", 32'(dive_count), 32'd2);
      run_while(0, n); chk("spawn_len_3", 32'(n), 32'd4);
      run_while(1, n); chk("cruise_enraged", 32'(n), 32'd8);
      run_while(0, n); chk("wait_enraged", 32'(n), 32'd2);
      tick(); tick();

      // asynchronous reset mid-dive
      chk("pre_reset_dive", 32'(boss_flydown), 32'd1);
      Reset_n = 1'b0;
      #1;
      m_reset();
      chk("async_reset", dut_vec(), 32'd0);
      tick();
      Reset_n = 1'b1;
      tick();
      chk("after_reset", dut_vec(), 32'd0);

      // stagger fire at level 0
      difficulty = 3'b100;
      start_boss = 1'b1;
      tick();
      start_boss = 1'b0;
      chk("stagger_spawn", 32'(boss_hold), 32'd1);
      for (int i = 0; i < 5; i++) begin
         wait_shot(n, v);
         chk("stagger_gap", 32'(n), 32'd7);
         chk("stagger_gun", 32'(v), 32'(4'h1 << (i % 4)));
         tick();
      end

      for (int i = 0; i < 3000; i++) begin
         Reset_n    = ($urandom_range(0, 499) != 0);
         start_boss = ($urandom_range(0, 9) != 0);
         beat_boss  = ($urandom_range(0, 149) == 0);
         hit_bottom = ($urandom_range(0, 5) == 0);
         hit_top    = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 63) == 0) difficulty = 3'($urandom_range(0, 7));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
